// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - EX-stage multiply/divide unit handshake and result bundle
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, in_a, in_b, flush,
        input  busy, stall, done, result, hi, lo
    );

    modport slave (
        input  start, op, in_a, in_b, flush,
        output busy, stall, done, result, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    ex_muldiv_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int W2    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] hi_q, lo_q, raw_a;
    logic [W2-1:0]    acc, mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic             is_div, neg_res, neg_rem, div_zero, done_q;

    logic             accept, last_iter, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
    logic [W2-1:0]    prod;
    logic [WIDTH:0]   sh_rem, diff;

    assign accept    = (state == IDLE) && bus.start && !bus.flush;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign a_neg     = !bus.op[0] && bus.in_a[WIDTH-1];
    assign b_neg     = !bus.op[0] && bus.in_b[WIDTH-1];
    // Most-negative input negates to itself, which read unsigned is 2^(WIDTH-1).
    assign mag_a     = a_neg ? -bus.in_a : bus.in_a;
    assign mag_b     = b_neg ? -bus.in_b : bus.in_b;

    // Restoring step: {remainder, next dividend bit} minus divisor.
    assign sh_rem = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    assign diff   = sh_rem - {1'b0, mcand[WIDTH-1:0]};

    assign prod = neg_res ? -acc : acc;
    assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_rem ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && !bus.op[2]) state_nx = bus.op[1] ? DIV : MUL;
            MUL:     if (last_iter) state_nx = FIX;
            DIV:     if (last_iter) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            raw_a    <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !bus.op[2]) begin
                        is_div   <= bus.op[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (bus.in_b == '0);
                        raw_a    <= bus.in_a;
                        cnt      <= '0;
                        mplier   <= mag_b;
                        if (bus.op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, mag_a};
                            mcand <= {{WIDTH{1'b0}}, mag_b};
                        end else begin
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, mag_a};
                        end
                    end else if (accept && bus.op[2] && bus.op[1]) begin
                        if (bus.op[0]) lo_q <= bus.in_a;
                        else           hi_q <= bus.in_a;
                    end
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                DIV: begin
                    if (!diff[WIDTH]) acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else              acc <= {sh_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (!is_div) begin
                            {hi_q, lo_q} <= prod;
                        end else if (div_zero) begin
                            lo_q <= '1;
                            hi_q <= raw_a;
                        end else begin
                            lo_q <= quo;
                            hi_q <= rem;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.result = '0;
        if (bus.op == 3'b100) bus.result = hi_q;
        if (bus.op == 3'b101) bus.result = lo_q;
    end

    assign bus.busy  = (state != IDLE);
    assign bus.stall = bus.start && (state != IDLE);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized and directed checks of ex_muldiv_unit against an arithmetic model
module tb_ex_muldiv_unit;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ex_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    ex_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} computed directly from the instruction semantics.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (op)
            3'd0: res = sa * sb;
            3'd1: res = ua * ub;
            3'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Issues a mul/div from an accept-ready cycle; returns at #1 after the done edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        bus.op = op;
        bus.in_a = a;
        bus.in_b = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_accept", {63'd0, bus.busy}, 64'd1);
        lat = 0;
        while (!bus.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        bus.op = op;
        bus.in_a = a;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    logic [63:0] exp_hl;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          lat;
    bit          done_seen;

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        bus.start = 1'b1;
        chk("reset_stall", {63'd0, bus.stall}, 64'd0);
        bus.start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        // MULT -3 x 7, then MFLO/MFHI in the done cycle
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, lat);
        chk("mult_latency", 64'(lat), 64'd33);
        chk("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_done_busy", {63'd0, bus.busy}, 64'd0);
        bus.start = 1'b1;
        bus.op = 3'b101;
        #1;
        chk("mflo_result", {32'd0, bus.result}, 64'h0000_0000_FFFF_FFEB);
        chk("done_cycle_stall", {63'd0, bus.stall}, 64'd0);
        bus.op = 3'b100;
        #1;
        chk("mfhi_result", {32'd0, bus.result}, 64'h0000_0000_FFFF_FFFF);
        bus.op = 3'b000;
        #1;
        chk("mult_op_result_zero", {32'd0, bus.result}, 64'd0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, bus.done}, 64'd0);

        // directed boundary cases
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat);
        chk("div_neg7_2", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_latency", 64'(lat), 64'd33);
        run_op(3'd3, 32'h1234_5678, 32'd0, lat);
        chk("divu_by_zero", {bus.hi, bus.lo}, 64'h1234_5678_FFFF_FFFF);
        chk("divz_latency", 64'(lat), 64'd33);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("div_overflow", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0, lat);
        chk("div_neg_by_zero", {bus.hi, bus.lo}, 64'hFFFF_FFF9_FFFF_FFFF);

        // MTHI presented while busy: stalled, then taken the cycle after done
        exp_hl = {bus.hi, bus.lo};
        bus.op = 3'd3;
        bus.in_a = 32'd100;
        bus.in_b = 32'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.op = 3'b110;
        bus.in_a = 32'hA5A5_A5A5;
        chk("mthi_busy_stall", {63'd0, bus.stall}, 64'd1);
        @(posedge clk); #1;
        chk("mthi_busy_hi", {32'd0, bus.hi}, {32'd0, exp_hl[63:32]});
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("divu_latency_stalled", 64'(lat), 64'd33);
        chk("divu_100_7", {bus.hi, bus.lo}, {32'd2, 32'd14});
        chk("mthi_done_stall", {63'd0, bus.stall}, 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("mthi_retry", {bus.hi, bus.lo}, {32'hA5A5_A5A5, 32'd14});

        // reset pulse 10 cycles into a DIV
        bus.op = 3'd2;
        bus.in_a = 32'd1000;
        bus.in_b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midop_reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("midop_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) done_seen = 1'b1;
        end
        chk("midop_reset_no_done", {63'd0, done_seen}, 64'd0);

        // flush 5 cycles into a MULT
        mt(3'b110, 32'h0000_5678);
        mt(3'b111, 32'h0000_1234);
        chk("mt_hilo", {bus.hi, bus.lo}, 64'h0000_5678_0000_1234);
        bus.op = 3'd0;
        bus.in_a = 32'd9;
        bus.in_b = 32'd9;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_busy", {63'd0, bus.busy}, 64'd0);
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) done_seen = 1'b1;
        end
        chk("flush_no_done", {63'd0, done_seen}, 64'd0);
        chk("flush_hilo", {bus.hi, bus.lo}, 64'h0000_5678_0000_1234);

        // flush together with start in IDLE drops the start
        bus.op = 3'b111;
        bus.in_a = 32'hDEAD_BEEF;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.op = 3'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start_idle", {63'd0, bus.busy}, 64'd0);
        chk("flush_start_lo", {32'd0, bus.lo}, 64'h0000_0000_0000_1234);

        // back-to-back issue in the done cycle
        run_op(3'd0, 32'd2, 32'd3, lat);
        chk("b2b_first", {32'd0, bus.lo}, 64'd6);
        run_op(3'd0, 32'd4, 32'd5, lat);
        chk("b2b_latency", 64'(lat), 64'd33);
        chk("b2b_second", {bus.hi, bus.lo}, 64'd20);

        // randomized mul/div against the model
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            exp_hl = model(rop, ra, rb);
            run_op(rop, ra, rb, lat);
            chk($sformatf("rand_op%0d_lat", rop), 64'(lat), 64'd33);
            chk($sformatf("rand_op%0d_%h_%h", rop, ra, rb), {bus.hi, bus.lo}, exp_hl);
        end

        // randomized MT/MF round trips
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            mt(3'b110, ra);
            mt(3'b111, rb);
            bus.op = 3'b100;
            #1;
            chk("rand_mfhi", {32'd0, bus.result}, {32'd0, ra});
            bus.op = 3'b101;
            #1;
            chk("rand_mflo", {32'd0, bus.result}, {32'd0, rb});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
